// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS IF stage owning the PC, the fetch address and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetched/stall/flush performance counter outputs.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          IMEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes
`endif
);

    // Wraps addresses modulo the memory size and forces word alignment in one mask.
    localparam logic [31:0] ADDR_MASK = (32'(IMEM_BYTES) - 32'd1) & ~32'd3;

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] next_pc;
    logic        redirect;
    logic        bubble;

    assign pc_seq   = (pc + 32'd4) & ADDR_MASK;
    assign redirect = branch_taken | jump;
    assign bubble   = redirect | flush;
    assign imem_pc  = pc;

    always_comb begin
        next_pc = pc_seq;
        if (branch_taken) begin
            next_pc = branch_target & ADDR_MASK;
        end else if (jump) begin
            next_pc = jump_target & ADDR_MASK;
        end else if (stall) begin
            next_pc = pc;
        end
    end

    // A redirect or flush bubbles IF/ID even under stall: the held ID instruction is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_inst  <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else begin
            pc <= next_pc;
            if (bubble) begin
                if_id_inst  <= 32'h0;
                if_id_pc4   <= 32'h0;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                if_id_inst  <= imem_inst;
                if_id_pc4   <= pc_seq;
                if_id_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_stalls  <= 32'h0;
            perf_flushes <= 32'h0;
        end else begin
            if (!bubble && !stall) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && !redirect) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
            if (bubble) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed vectors for the IF stage, checked by a queue-based scoreboard.
// Compile with FETCH_PERF_CNT_EN defined to also check the performance counters.
module tb_instruction_fetch_stage;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] perf_flushes;
`endif

    logic [31:0] mem [32];
    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          vecNum = 0;

    instruction_fetch_stage #(
        .RESET_PC  (32'h0),
        .IMEM_BYTES(128)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_pc      (imem_pc),
        .imem_inst    (imem_inst),
        .if_id_inst   (if_id_inst),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word at byte address a is 0x1000_0000 | a, except address 0 which holds lui $t0,0.
    initial begin
        for (int k = 0; k < 32; k++) begin
            mem[k] = 32'h1000_0000 | 32'(k * 4);
        end
        mem[0] = 32'h3C08_0000;
    end
    assign imem_inst = mem[imem_pc[6:2]];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compare($sformatf("vec%0d.imem_pc", e.idx), imem_pc, e.pc);
        compare($sformatf("vec%0d.if_id_inst", e.idx), if_id_inst, e.inst);
        compare($sformatf("vec%0d.if_id_pc4", e.idx), if_id_pc4, e.pc4);
        compare($sformatf("vec%0d.if_id_valid", e.idx), {31'h0, if_id_valid}, {31'h0, e.valid});
    endtask

    // Drives one cycle of inputs and queues the state expected just after the following edge.
    task automatic applyStimulus(
        input logic r, input logic st, input logic fl,
        input logic br, input logic [31:0] bt,
        input logic j, input logic [31:0] jt,
        input logic [31:0] epc, input logic [31:0] einst,
        input logic [31:0] epc4, input logic ev
    );
        exp_t e;
        rst           = r;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        @(posedge clk);
        #1;
        vecNum++;
        e.idx   = vecNum;
        e.pc    = epc;
        e.inst  = einst;
        e.pc4   = epc4;
        e.valid = ev;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            checkOutput(q.pop_front());
        end
    end

    initial begin
        int waitCycles;
        // Reset held two cycles
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0,  32'h00, 32'h0000_0000, 32'h00, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0,  32'h00, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,  32'h04, 32'h3C08_0000, 32'h04, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,  32'h08, 32'h1000_0004, 32'h08, 1);
        // Stall three cycles at pc=8
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0,  32'h08, 32'h1000_0004, 32'h08, 1);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0,  32'h08, 32'h1000_0004, 32'h08, 1);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0,  32'h08, 32'h1000_0004, 32'h08, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,  32'h0C, 32'h1000_0008, 32'h0C, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,  32'h10, 32'h1000_000C, 32'h10, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,  32'h14, 32'h1000_0010, 32'h14, 1);
        // Branch to 0x40 from 0x14
        applyStimulus(0, 0, 0, 1, 32'h40, 0, 32'h0, 32'h40, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,  32'h44, 32'h1000_0040, 32'h44, 1);
        // Priority: branch over jump over stall
        applyStimulus(0, 1, 0, 1, 32'h20, 1, 32'h30, 32'h20, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h30,  32'h30, 32'h0000_0000, 32'h00, 0);
        // Flush alone advances pc; flush with stall holds pc but still bubbles
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0,  32'h34, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0,  32'h34, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,  32'h38, 32'h1000_0034, 32'h38, 1);
        // Wrap at the top of memory and alignment of targets
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h7C,  32'h7C, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,   32'h00, 32'h1000_007C, 32'h00, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h87,  32'h04, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FF42, 0, 32'h0, 32'h40, 32'h0000_0000, 32'h00, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,   32'h44, 32'h1000_0040, 32'h44, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,   32'h48, 32'h1000_0044, 32'h48, 1);
        // Reset mid-operation overrides stall and branch
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h24,  32'h24, 32'h0000_0000, 32'h00, 0);
        applyStimulus(1, 1, 0, 1, 32'h40, 0, 32'h0,  32'h00, 32'h0000_0000, 32'h00, 0);
`ifdef FETCH_PERF_CNT_EN
        compare("perf_fetched.after_rst", perf_fetched, 32'd0);
        compare("perf_stalls.after_rst", perf_stalls, 32'd0);
        compare("perf_flushes.after_rst", perf_flushes, 32'd0);
`endif
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0,   32'h04, 32'h3C08_0000, 32'h04, 1);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0,   32'h04, 32'h3C08_0000, 32'h04, 1);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0,   32'h08, 32'h0000_0000, 32'h00, 0);
`ifdef FETCH_PERF_CNT_EN
        compare("perf_fetched.end", perf_fetched, 32'd1);
        compare("perf_stalls.end", perf_stalls, 32'd1);
        compare("perf_flushes.end", perf_flushes, 32'd1);
`endif
        waitCycles = 0;
        while (q.size() > 0 && waitCycles < 5) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
